// File: rtl/unary_to_bin_11_if.sv
// Sum output port of unary_to_bin_11: a valid/ready handshake carrying the
// recovered binary sum and its status flags.
//   sum        {ovf, count}, CW+1 bits
//   sum_valid  sum/ovf/trunc are valid and held until accepted
//   ovf        adder count wrapped past 2^CW-1
//   trunc      write phase was cut short by read_or_write falling
//   sum_ready  consumer accepts the sum this cycle
// master: the collector (drives the sum); slave: the consumer.
interface unary_to_bin_11_if #(
  parameter int unsigned CW = 11
);
  logic [CW:0] sum;
  logic        sum_valid;
  logic        ovf;
  logic        trunc;
  logic        sum_ready;

  modport master (
    output sum,
    output sum_valid,
    output ovf,
    output trunc,
    input  sum_ready
  );

  modport slave (
    input  sum,
    input  sum_valid,
    input  ovf,
    input  trunc,
    output sum_ready
  );
endinterface

// File: rtl/unary_to_bin_11.sv
// Collector stage behind the unary adder. It ORs the adder carry into ovf
// during the read phase, then counts unary dout pulses during the write phase
// and presents {ovf, count} on a valid/ready port.
//   clk            rising-edge clock shared with the adder
//   rst            synchronous active-high reset
//   en             adder enable; all sampling is qualified by it
//   read_or_write  0 = read/accumulate, 1 = write/drain
//   dout_in        adder's registered unary pulse output
//   c_in           adder's registered carry flag
//   sum_port       valid/ready sum output (sum, sum_valid, ovf, trunc, sum_ready)
//   busy           high whenever a frame is open or a sum is waiting
module unary_to_bin_11 #(
  parameter int unsigned CW = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      read_or_write,
  input  logic                      dout_in,
  input  logic                      c_in,
  unary_to_bin_11_if.master         sum_port,
  output logic                      busy
);

  localparam logic [CW-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWcount,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          trunc_q, trunc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    trunc_d = trunc_q;

    unique case (state_q)
      StIdle: begin
        // Opening a frame; c_in still belongs to whatever preceded it.
        if (en && !read_or_write) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          trunc_d = 1'b0;
          state_d = StRead;
        end
      end

      StRead: begin
        // Carry on the read->write edge is from the last read cycle, so it
        // still counts; dout_in on that edge is stale read-phase data.
        if (en) begin
          ovf_d = ovf_q | c_in;
          if (read_or_write) state_d = StWcount;
        end
      end

      StWcount: begin
        if (en) begin
          if (!read_or_write) begin
            trunc_d = 1'b1;
            state_d = StDone;
          end else if (dout_in) begin
            // Saturate rather than wrap if the pulse stream overruns.
            if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        if (sum_port.sum_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign sum_port.sum       = {ovf_q, cnt_q};
  assign sum_port.ovf       = ovf_q;
  assign sum_port.trunc     = trunc_q;
  assign sum_port.sum_valid = (state_q == StDone);
  assign busy               = (state_q != StIdle);

endmodule

// File: doc/unary_to_bin_11.md
# unary_to_bin_11

Downstream stage of the 11-bit unary adder. During the adder's read phase it captures the adder's carry flag, and it tracks the phase itself. During the write phase it counts the adder's unary output pulses and converts them back to a 12-bit binary sum (carry bit plus 11-bit count). The sum is presented on a valid/ready output port and held until the consumer accepts it.

## Interface
- CW, 11, width of the pulse counter; must match the adder's count width.
- clk  in  1  rising-edge clock, shared with the adder.
- rst  in  1  synchronous, active-high reset.
- en  in  1  same enable that drives the adder; all sampling happens only on cycles with en=1.
- read_or_write  in  1  phase select shared with the adder; 0 = read/accumulate, 1 = write/drain.
- dout_in  in  1  adder's registered dout (unary pulse stream).
- c_in  in  1  adder's registered carry flag C.
- sum_ready  in  1  consumer accepts sum this cycle.
- sum  out  CW+1  {ovf, count}; true value of the adder frame.
- sum_valid  out  1  sum/ovf/trunc are valid.
- ovf  out  1  adder count wrapped (sum ≥ 2^CW).
- trunc  out  1  write phase ended by read_or_write falling before dout_in went low.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, READ, WCOUNT, DONE. All transitions are evaluated only when en=1, except for the DONE handshake.
- IDLE: on en && read_or_write=0, clear cnt, ovf and trunc, then go to READ. c_in is not sampled on this cycle.
- IDLE: en && read_or_write=1 is ignored, because the block has no frame open.
- READ, every en cycle: ovf |= c_in. If read_or_write=1, go to WCOUNT.
  - On that transition cycle, c_in reflects the last read cycle of the adder. It is still ORed into ovf.
  - On that transition cycle, dout_in is ignored because it still reflects the read phase.
- WCOUNT, every en cycle:
  - read_or_write=0: set trunc=1 and go to DONE. dout_in is ignored.
  - read_or_write=1 and dout_in=1: cnt <= cnt+1.
  - read_or_write=1 and dout_in=0: go to DONE. This is the normal end of the frame.
- DONE: sum_valid=1. sum, ovf and trunc are frozen. On sum_valid && sum_ready, go to IDLE and drop sum_valid.
- DONE ignores en, read_or_write, dout_in and c_in. A frame started while in DONE is not captured; upstream must not start a new frame before the handshake.
- cnt is CW bits. The adder cannot emit more than 2^CW−1 pulses, but cnt saturates at 2^CW−1 as a guard and never wraps.
- sum = {ovf, cnt}. An adder frame totalling 2048 yields ovf=1, cnt=0, sum=2048.
- busy = (state ≠ IDLE).

## Timing
- Reset (rst=1 at a rising edge): state=IDLE, cnt=0, sum=0, sum_valid=0, ovf=0, trunc=0, busy=0. Reset overrides everything, including DONE with an unaccepted sum, and discards that sum.
- Adder outputs lag its inputs by one en cycle; the collector consumes them with that lag.
- Example with en held high: read_or_write rises in cycle k. The N pulses appear in cycles k+1..k+N. The edge at k+N+1 samples dout_in=0, and sum_valid is high from cycle k+N+2.
- Zero-count frame: the edge of cycle k+1 samples dout_in=0, so sum_valid=1, sum=0.
- Gaps in en stall all sampling. Pulses are counted once per en cycle, never once per clk.
- sum_valid stays high until the handshake.
  - sum_ready may be held high permanently; then sum_valid lasts exactly one cycle.
  - sum_ready while sum_valid=0 has no effect.

## Test plan
- Reset mid-WCOUNT after 5 pulses (rst=1 one cycle) -> all outputs 0, state IDLE; the next frame (A=1 for 3 cycles) produces sum=3, with no residue from the 5 pulses.
- Frame: A=B=1 for 3 read cycles, then write -> exactly 6 pulses counted, sum=6, ovf=0, trunc=0; with sum_ready=1 permanently, sum_valid is high for one cycle.
- Overflow: drive the adder to count 2047, then one cycle of A=1 (C=1) -> sum=2048 (ovf=1, cnt=0). A separate frame with count 2046 and A=B=1 -> sum=2048, ovf=1.
- Empty frame: read phase with A=B=0, then read_or_write=1 -> sum=0, ovf=0; sum_valid rises 2 cycles after read_or_write rises.
- en gaps: 10-pulse frame with en toggling 1/0 every cycle during the write phase -> sum=10, not 20; sum_valid holds while sum_ready=0 for 7 cycles, then drops the cycle after sum_ready=1.
- Truncation: drop read_or_write to 0 after 4 of 9 pulses -> DONE with sum=4, trunc=1; a new frame started while in DONE is ignored, and busy stays 1 until the handshake.
